timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Control stage directly upstream of the 8-bit up/down counter.
- Drives the counter's load, enable, direction and load-data inputs, and watches its terminal-count and value outputs.
- Turns a software-style start/stop request into one-shot or auto-reload timing runs.
- Reports each expiry as a done pulse, a sticky interrupt and an expiry count.

Parameters:
- WIDTH, 8, width of the period value and of the counter data path.
- EVT_W, 16, width of the expiry event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin a run; sampled only in IDLE.
- stop  input  1  abort the current run.
- cfg_period  input  WIDTH  reload value; latched on an accepted start.
- cfg_dir  input  1  count direction; 1 = up, 0 = down; latched on an accepted start.
- cfg_auto  input  1  1 = auto-reload, 0 = one-shot; latched on an accepted start.
- irq_clr  input  1  clears irq.
- cnt_terminate  input  1  counter terminal-count flag; 1 when the counter value is 0.
- cnt_value  input  WIDTH  counter value; debug and status only, unused by the FSM.
- cnt_load  output  1  counter load strobe.
- cnt_enable  output  1  counter enable.
- cnt_up_down  output  1  counter direction; 1 = up.
- cnt_data  output  WIDTH  counter load data.
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle pulse per expiry.
- err  output  1  one-cycle pulse on a rejected start.
- irq  output  1  sticky expiry interrupt.
- evt_count  output  EVT_W  number of expiries since the last accepted start.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the state goes to IDLE and every output goes to 0, including cnt_data, evt_count and the latched config. This applies from any state; there is no partial completion of a run.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - cnt_load=0, cnt_enable=0, busy=0; the counter holds its value.
  - start=1 with cfg_period!=0: latch cfg_period, cfg_dir and cfg_auto; clear evt_count; go to LOAD.
  - start=1 with cfg_period==0: err=1 for one cycle; stay in IDLE; config is not latched.
- LOAD (one cycle):
  - cnt_load=1, cnt_enable=1, cnt_data=latched period, cnt_up_down=latched dir.
  - The counter captures the period at the end of this cycle.
  - Next state is RUN.
- RUN:
  - cnt_load=0, cnt_enable=1.
  - The first RUN cycle always sees a nonzero counter, so cnt_terminate=0.
  - Expiry is an edge in RUN where cnt_terminate=1. On that edge: done=1 in the next cycle; irq=1; evt_count increments and wraps at 2^EVT_W.
  - After expiry, next state is LOAD if latched auto=1 and stop=0; otherwise IDLE.
- Timing:
  - Down mode: expiry is P+2 edges after the edge that accepted start.
  - Up mode: the counter wraps from 2^WIDTH-1 to 0, so expiry is (2^WIDTH-P)+2 edges after the accepted start.
  - Auto-reload: done pulses repeat with the same spacing, P+2 in down mode.
- stop:
  - stop=1 in LOAD or RUN with no expiry on that edge: go to IDLE with no done and no irq. The counter freezes at its current value.
  - stop and expiry on the same edge: done, irq and evt_count still update, and the FSM goes to IDLE (no reload).
  - stop in IDLE is ignored.
- start in LOAD or RUN is ignored.
- cfg_* changes during a run are ignored; each auto-reload uses the latched period and direction.
- irq: set has priority over irq_clr on the same edge; otherwise irq_clr=1 clears it.
- cnt_up_down and cnt_data hold their latched values in IDLE after a run.

Test Plan:
- Reset, then start with period=5, dir=0, auto=0 -> cnt_load high for exactly 1 cycle; done pulses once 7 edges after start; FSM returns to IDLE; irq=1; evt_count=1; busy low in the cycle done is high.
- Period=3, dir=0, auto=1, run for 20 cycles, then stop -> done every 5 cycles (4 pulses); evt_count=4; no done after stop; busy=0 the cycle after stop.
- Period=250, dir=1, auto=0 -> counter runs 250 to 255, then 0; done 8 edges after start.
- Start with period=0 -> err pulses for 1 cycle; busy stays 0; cnt_load never asserts; evt_count is unchanged.
- Assert stop and irq_clr on the same edge as the expiry -> done=1; irq remains 1; FSM goes to IDLE with no reload.
- Assert rst_n=0 mid-RUN for 1 cycle -> all outputs 0 on the next cycle; a start pulse issued one cycle earlier has no residual effect.

Source files
------------

// File: rtl/timer_ctrl.sv
// Control FSM in front of an 8-bit up/down counter: turns start/stop requests
// into one-shot or auto-reload timing runs and reports expiries.
module timer_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_dir,
  input  logic             cfg_auto,
  input  logic             irq_clr,
  input  logic             cnt_terminate,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             cnt_up_down,
  output logic [WIDTH-1:0] cnt_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             irq,
  output logic [EVT_W-1:0] evt_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_q, state_d;
  logic               auto_q, auto_d;
  logic               dir_d;
  logic [WIDTH-1:0]   period_d;
  logic [EVT_W-1:0]   evt_d;
  logic               done_d, err_d, irq_d, expire;

  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    dir_d    = cnt_up_down;
    period_d = cnt_data;
    evt_d    = evt_count;
    done_d   = 1'b0;
    err_d    = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_period != '0) begin
            period_d = cfg_period;
            dir_d    = cfg_dir;
            auto_d   = cfg_auto;
            evt_d    = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: state_d = stop ? IDLE : RUN;
      RUN: begin
        if (cnt_terminate) begin
          expire  = 1'b1;
          done_d  = 1'b1;
          evt_d   = evt_count + EVT_W'(1);
          state_d = (auto_q && !stop) ? LOAD : IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new expiry wins over a simultaneous clear.
    irq_d = expire | (irq & ~irq_clr);
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      auto_q      <= 1'b0;
      cnt_load    <= 1'b0;
      cnt_enable  <= 1'b0;
      cnt_up_down <= 1'b0;
      cnt_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      irq         <= 1'b0;
      evt_count   <= '0;
    end else begin
      state_q     <= state_d;
      auto_q      <= auto_d;
      cnt_load    <= (state_d == LOAD);
      cnt_enable  <= (state_d != IDLE);
      cnt_up_down <= dir_d;
      cnt_data    <= period_d;
      busy        <= (state_d != IDLE);
      done        <= done_d;
      err         <= err_d;
      irq         <= irq_d;
      evt_count   <= evt_d;
    end
  end

  // cnt_value is status only; it is used here just to cross-check the flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt_terminate == (cnt_value == '0))
        else $error("cnt_terminate inconsistent with cnt_value");
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural up/down counter attached.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  cfg_period = '0;
  logic        cfg_dir = 1'b0;
  logic        cfg_auto = 1'b0;
  logic        irq_clr = 1'b0;
  logic        cnt_terminate;
  logic [7:0]  cnt_value = '0;
  logic        cnt_load, cnt_enable, cnt_up_down;
  logic [7:0]  cnt_data;
  logic        busy, done, err, irq;
  logic [15:0] evt_count;

  int n_checks = 0;
  int n_fail = 0;

  timer_ctrl #(.WIDTH(8), .EVT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_dir(cfg_dir), .cfg_auto(cfg_auto),
    .irq_clr(irq_clr), .cnt_terminate(cnt_terminate), .cnt_value(cnt_value),
    .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down),
    .cnt_data(cnt_data), .busy(busy), .done(done), .err(err), .irq(irq),
    .evt_count(evt_count)
  );

  always #5 clk = ~clk;

  // Downstream counter environment
  always @(posedge clk) begin
    if (!rst_n)          cnt_value <= '0;
    else if (cnt_load)   cnt_value <= cnt_data;
    else if (cnt_enable) cnt_value <= cnt_up_down ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end
  assign cnt_terminate = (cnt_value == 8'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst_n, start, stop;
    logic [7:0] period;
    logic       dir, auto_r, clr;
    logic       busy, load, en, done, err, irq;
    logic [15:0] evt;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int ndone;
    int n;
    logic [31:0] act_v, exp_v;

    // inputs applied before an edge, outputs expected just after it
    vecs[0]  = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,8'd0};
    vecs[1]  = '{1'b1,1'b1,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[2]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[3]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[4]  = '{1'b1,1'b1,1'b0,8'd9,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[5]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[6]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[7]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,16'd0,8'd5};
    vecs[8]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd1,8'd5};
    vecs[9]  = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd1,8'd5};
    vecs[10] = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1,8'd5};
    vecs[11] = '{1'b1,1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd1,8'd5};
    vecs[12] = '{1'b1,1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1,8'd5};

    #2;
    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; stop = vecs[i].stop;
      cfg_period = vecs[i].period; cfg_dir = vecs[i].dir;
      cfg_auto = vecs[i].auto_r; irq_clr = vecs[i].clr;
      tick();
      act_v = {2'b0, busy, cnt_load, cnt_enable, done, err, irq, evt_count, cnt_data};
      exp_v = {2'b0, vecs[i].busy, vecs[i].load, vecs[i].en, vecs[i].done,
               vecs[i].err, vecs[i].irq, vecs[i].evt, vecs[i].data};
      chk($sformatf("vec%0d", i), act_v, exp_v);
    end
    start = 0; irq_clr = 0;

    // auto-reload, period 3 down: done every 5 edges; cfg edits mid-run ignored
    start = 1; cfg_period = 8'd3; cfg_dir = 0; cfg_auto = 1;
    tick();
    start = 0; cfg_period = 8'd9; cfg_dir = 1;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        ndone++;
        chk($sformatf("auto_spacing_e%0d", i), i % 5, 0);
      end
    end
    chk("auto_done_count", ndone, 4);
    chk("auto_evt_count", evt_count, 4);
    stop = 1;
    tick();
    stop = 0;
    chk("auto_busy_after_stop", busy, 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("auto_no_done_after_stop", ndone, 0);
    chk("auto_latched_period", cnt_data, 3);
    chk("auto_latched_dir", cnt_up_down, 0);

    // up mode, period 250: expiry 8 edges after start
    start = 1; cfg_period = 8'd250; cfg_dir = 1; cfg_auto = 0;
    tick();
    start = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 20);
    chk("up_expiry_edges", n, 8);
    chk("up_dir", cnt_up_down, 1);
    chk("up_busy_at_done", busy, 0);

    // stop + irq_clr on the expiry edge
    irq_clr = 1;
    tick();
    irq_clr = 0;
    chk("irq_cleared", irq, 0);
    start = 1; cfg_period = 8'd4; cfg_dir = 0; cfg_auto = 1;
    tick();
    start = 0;
    repeat (5) tick();
    stop = 1; irq_clr = 1;
    tick();
    stop = 0; irq_clr = 0;
    chk("stopexp_done", done, 1);
    chk("stopexp_irq", irq, 1);
    chk("stopexp_busy", busy, 0);
    chk("stopexp_evt", evt_count, 1);
    tick();
    chk("stopexp_no_reload", {busy, cnt_load, done}, 0);

    // stop mid-RUN with no expiry
    irq_clr = 1;
    tick();
    irq_clr = 0;
    start = 1; cfg_period = 8'd10; cfg_auto = 0;
    tick();
    start = 0;
    repeat (3) tick();
    stop = 1;
    tick();
    stop = 0;
    chk("stop_mid_run", {busy, cnt_enable, done, irq}, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("stop_mid_run_no_done", ndone, 0);

    // reset mid-RUN, with a start pulse one cycle before
    start = 1; cfg_period = 8'd10; cfg_auto = 1;
    tick();
    start = 0;
    repeat (3) tick();
    start = 1;
    tick();
    start = 0; rst_n = 0;
    tick();
    rst_n = 1;
    chk("reset_outputs", {cnt_load, cnt_enable, cnt_up_down, busy, done, err, irq,
                          evt_count, cnt_data}, 0);
    repeat (2) tick();
    chk("after_reset_idle", {busy, cnt_load, done}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
